dds_wave_gen: RTL and testbench

Direct-digital-synthesis waveform core of the signal generator; the first stage clocked and reset by the global reset controller (FPGA_CLK 25 MHz, RST_n). Accepts a frequency tuning word and waveform selection over a valid/ready handshake, runs a phase accumulator, and produces registered DAC samples. Parameter updates are applied only at phase wrap, so the output never glitches mid-period.

---
 rtl/dds_wave_gen.sv | 196 +++++++++++++++++++
 tb/tb_dds_wave_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform core.
// A tuning word, a waveform select and a square duty threshold arrive over a
// valid/ready handshake. They are parked in a pending register and become
// active only at a phase wrap, so a period is never cut short.
// Optional feature macro: DDS_SINE_EN. When it is defined, wave_sel = 3 selects
// a quarter-wave sine ROM and DAC_W must be 8. When it is undefined, wave_sel = 3
// gives constant mid-scale.
module dds_wave_gen #(
    parameter int PHASE_W = 32,
    parameter int DAC_W   = 8
) (
    input  logic               FPGA_CLK,
    input  logic               RST_n,
    input  logic               enable,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [1:0]         wave_sel,
    input  logic [DAC_W-1:0]   duty,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic [DAC_W-1:0]   dac_data,
    output logic               dac_valid,
    output logic               sync_pulse
);

    localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};

    if (DAC_W < 4) begin : g_bad_dac_w
        $error("dds_wave_gen: DAC_W must be at least 4");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [PHASE_W-1:0]  phase_reg, phase_next;
    logic [PHASE_W-1:0]  word_reg, pend_word_reg;
    logic [1:0]          sel_reg, pend_sel_reg;
    logic [DAC_W-1:0]    duty_reg, pend_duty_reg;
    logic                pend_reg;
    logic [PHASE_W:0]    sum;
    logic                carry, word_zero, apply, wrap, accept;
    logic                wrap_reg, wrap_d1_reg, valid_d1_reg;
    logic [DAC_W-1:0]    decode_reg, wave;
    logic [DAC_W-1:0]    p, q;

`ifdef DDS_SINE_EN
    if (DAC_W != 8) begin : g_bad_sine_w
        $error("dds_wave_gen: DDS_SINE_EN requires DAC_W == 8");
    end

    // First quarter of a sine, sampled at the centre of each of 64 steps.
    localparam logic [7:0] SINE_ROM [64] = '{
        8'd129, 8'd132, 8'd135, 8'd138, 8'd142, 8'd145, 8'd148, 8'd151,
        8'd154, 8'd157, 8'd160, 8'd163, 8'd166, 8'd169, 8'd172, 8'd175,
        8'd178, 8'd181, 8'd183, 8'd186, 8'd189, 8'd192, 8'd194, 8'd197,
        8'd200, 8'd202, 8'd205, 8'd207, 8'd210, 8'd212, 8'd214, 8'd217,
        8'd219, 8'd221, 8'd223, 8'd225, 8'd227, 8'd229, 8'd231, 8'd233,
        8'd234, 8'd236, 8'd238, 8'd239, 8'd241, 8'd242, 8'd243, 8'd245,
        8'd246, 8'd247, 8'd248, 8'd249, 8'd250, 8'd251, 8'd252, 8'd252,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255
    };
    logic [1:0] sine_quad;
    logic [5:0] sine_idx;
    logic [7:0] sine_rom_val, sine_val;
`endif

    assign sum       = {1'b0, phase_reg} + {1'b0, word_reg};
    assign carry     = sum[PHASE_W];
    assign word_zero = (word_reg == '0);
    assign cfg_ready = ~pend_reg;
    assign accept    = cfg_valid & ~pend_reg;

    // Next state, next phase, and when the pending config may be applied.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        apply      = 1'b0;
        wrap       = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next = '0;
                apply      = pend_reg;
                if (enable) state_next = RUN;
            end
            RUN: begin
                phase_next = sum[PHASE_W-1:0];
                wrap       = carry;
                // With a zero word no wrap will ever come, so apply at once.
                apply      = pend_reg & (carry | word_zero);
                if (!enable) state_next = STOPPING;
            end
            STOPPING: begin
                if (enable) begin
                    phase_next = sum[PHASE_W-1:0];
                    wrap       = carry;
                    apply      = pend_reg & (carry | word_zero);
                    state_next = RUN;
                end else if (carry || word_zero) begin
                    phase_next = '0;
                    apply      = pend_reg;
                    state_next = IDLE;
                end else begin
                    phase_next = sum[PHASE_W-1:0];
                end
            end
            default: begin
                phase_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State, phase and wrap marker registers.
    always_ff @(posedge FPGA_CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            wrap_reg  <= wrap;
        end
    end

    // Pending config capture and promotion to the active set.
    always_ff @(posedge FPGA_CLK or negedge RST_n) begin
        if (!RST_n) begin
            pend_reg      <= 1'b0;
            pend_word_reg <= '0;
            pend_sel_reg  <= '0;
            pend_duty_reg <= '0;
            word_reg      <= '0;
            sel_reg       <= '0;
            duty_reg      <= '0;
        end else if (apply) begin
            pend_reg <= 1'b0;
            word_reg <= pend_word_reg;
            sel_reg  <= pend_sel_reg;
            duty_reg <= pend_duty_reg;
        end else if (accept) begin
            pend_reg      <= 1'b1;
            pend_word_reg <= freq_word;
            pend_sel_reg  <= wave_sel;
            pend_duty_reg <= duty;
        end
    end

    // Waveform decode from the top DAC_W bits of the phase.
    always_comb begin
        p    = phase_reg[PHASE_W-1 -: DAC_W];
        q    = {p[DAC_W-2:0], 1'b0};
        wave = MID;
`ifdef DDS_SINE_EN
        sine_quad    = p[DAC_W-1 -: 2];
        sine_idx     = sine_quad[0] ? ~p[5:0] : p[5:0];
        sine_rom_val = SINE_ROM[sine_idx];
        sine_val     = sine_quad[1] ? ~sine_rom_val : sine_rom_val;
`endif
        case (sel_reg)
            2'd0: wave = p;
            2'd1: wave = p[DAC_W-1] ? ~q : q;
            2'd2: wave = (p < duty_reg) ? '1 : '0;
            default: begin
`ifdef DDS_SINE_EN
                wave = sine_val;
`else
                wave = MID;
`endif
            end
        endcase
    end

    // Two-stage output pipeline: decode register, then the DAC register.
    always_ff @(posedge FPGA_CLK or negedge RST_n) begin
        if (!RST_n) begin
            valid_d1_reg <= 1'b0;
            wrap_d1_reg  <= 1'b0;
            decode_reg   <= MID;
            dac_data     <= MID;
            dac_valid    <= 1'b0;
            sync_pulse   <= 1'b0;
        end else begin
            valid_d1_reg <= (state_reg != IDLE);
            wrap_d1_reg  <= wrap_reg;
            decode_reg   <= (state_reg == IDLE) ? MID : wave;
            dac_data     <= decode_reg;
            dac_valid    <= valid_d1_reg;
            sync_pulse   <= wrap_d1_reg;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Testbench for dds_wave_gen: directed scenarios followed by random stimulus,
// every cycle checked against a behavioural model of the generator.
module tb_dds_wave_gen;

    localparam int PHASE_W = 32;
    localparam int DAC_W   = 8;
    localparam int MID     = 1 << (DAC_W - 1);
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STOP  = 2;

    logic               FPGA_CLK  = 1'b0;
    logic               RST_n     = 1'b1;
    logic               enable    = 1'b0;
    logic [PHASE_W-1:0] freq_word = '0;
    logic [1:0]         wave_sel  = '0;
    logic [DAC_W-1:0]   duty      = '0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [DAC_W-1:0]   dac_data;
    logic               dac_valid;
    logic               sync_pulse;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int data;
        bit valid;
        bit sync;
    } samp_t;

    // Behavioural model state.
    int                 m_mode;
    logic [PHASE_W-1:0] m_phase, m_word, p_word;
    logic [1:0]         m_sel, p_sel;
    logic [DAC_W-1:0]   m_duty, p_duty;
    bit                 m_pend, m_wrapped;
    samp_t              exp_q[$];

    dds_wave_gen #(.PHASE_W(PHASE_W), .DAC_W(DAC_W)) dut (
        .FPGA_CLK  (FPGA_CLK),
        .RST_n     (RST_n),
        .enable    (enable),
        .freq_word (freq_word),
        .wave_sel  (wave_sel),
        .duty      (duty),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .sync_pulse(sync_pulse)
    );

    always #20 FPGA_CLK = ~FPGA_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wave_of(input logic [PHASE_W-1:0] ph, input logic [1:0] sel,
                                   input logic [DAC_W-1:0] dt);
        int pv, half, top;
        pv   = int'(ph >> (PHASE_W - DAC_W));
        half = 1 << (DAC_W - 1);
        top  = (1 << DAC_W) - 1;
        case (sel)
            2'd0:    return pv;
            2'd1:    return (pv < half) ? 2 * pv : top - 2 * (pv - half);
            2'd2:    return (pv < int'(dt)) ? top : 0;
            default: return half;
        endcase
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_phase   = '0;
        m_word    = '0;
        m_sel     = '0;
        m_duty    = '0;
        p_word    = '0;
        p_sel     = '0;
        p_duty    = '0;
        m_pend    = 1'b0;
        m_wrapped = 1'b0;
        exp_q.delete();
        exp_q.push_back('{MID, 1'b0, 1'b0});
    endtask

    // One clock: predict, advance the model at the edge, check at the falling edge.
    task automatic step();
        samp_t              s, e;
        logic [63:0]        total;
        bit                 carry, do_apply, do_accept, n_wrapped, en;
        int                 n_mode;
        logic [PHASE_W-1:0] n_phase, in_word;
        logic [1:0]         in_sel;
        logic [DAC_W-1:0]   in_duty;

        s.data  = (m_mode == M_IDLE) ? MID : wave_of(m_phase, m_sel, m_duty);
        s.valid = (m_mode != M_IDLE);
        s.sync  = m_wrapped && (m_mode != M_IDLE);

        en        = enable;
        in_word   = freq_word;
        in_sel    = wave_sel;
        in_duty   = duty;
        total     = 64'(m_phase) + 64'(m_word);
        carry     = total >= (64'd1 << PHASE_W);
        do_accept = !m_pend && cfg_valid;
        n_wrapped = 1'b0;

        if (m_mode == M_IDLE) begin
            n_phase  = '0;
            n_mode   = en ? M_RUN : M_IDLE;
            do_apply = m_pend;
        end else if (m_mode == M_STOP && !en && (m_word == 0 || carry)) begin
            n_phase  = '0;
            n_mode   = M_IDLE;
            do_apply = m_pend;
        end else begin
            n_phase   = total[PHASE_W-1:0];
            n_mode    = en ? M_RUN : M_STOP;
            n_wrapped = carry;
            do_apply  = m_pend && (m_word == 0 || carry);
        end

        @(posedge FPGA_CLK);
        if (do_apply) begin
            m_word = p_word;
            m_sel  = p_sel;
            m_duty = p_duty;
            m_pend = 1'b0;
        end
        if (do_accept) begin
            p_word = in_word;
            p_sel  = in_sel;
            p_duty = in_duty;
            m_pend = 1'b1;
            $display("cfg accepted t=%0t word=%h sel=%0d duty=%h", $time, in_word, in_sel, in_duty);
        end
        m_phase   = n_phase;
        m_mode    = n_mode;
        m_wrapped = n_wrapped;
        exp_q.push_back(s);
        e = exp_q.pop_front();

        @(negedge FPGA_CLK);
        chk("dac_data", dac_data, e.data);
        chk("dac_valid", dac_valid, e.valid);
        chk("sync_pulse", sync_pulse, e.sync);
        chk("cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic send_cfg(input logic [PHASE_W-1:0] w, input logic [1:0] s,
                            input logic [DAC_W-1:0] d);
        freq_word = w;
        wave_sel  = s;
        duty      = d;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        bit found;
        model_reset();

        // Reset values
        #5 RST_n = 1'b0;
        @(negedge FPGA_CLK);
        chk("reset_dac_data", dac_data, MID);
        chk("reset_dac_valid", dac_valid, 0);
        chk("reset_sync", sync_pulse, 0);
        chk("reset_cfg_ready", cfg_ready, 1);
        @(negedge FPGA_CLK);
        RST_n = 1'b1;
        repeat (3) step();

        // Sawtooth, 16-cycle period
        enable = 1'b1;
        send_cfg(32'h1000_0000, 2'd0, 8'h00);
        repeat (40) step();

        // Triangle, 32-cycle period (applied at the next saw wrap)
        send_cfg(32'h0800_0000, 2'd1, 8'h00);
        repeat (80) step();

        // Square, duty 0x40, 256-cycle period
        send_cfg(32'h0100_0000, 2'd2, 8'h40);
        repeat (560) step();

        // Mid-period update at phase 0x5000_0000
        send_cfg(32'h1000_0000, 2'd0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (!m_pend && m_word == 32'h1000_0000 && m_phase == 32'h5000_0000) found = 1'b1;
            else step();
        end
        chk("reach_phase_5", found, 1);
        send_cfg(32'h2000_0000, 2'd0, 8'h00);
        chk("mid_update_ready_low", cfg_ready, 0);
        repeat (40) step();

        // Stop request at phase 0x3000_0000
        send_cfg(32'h1000_0000, 2'd0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (!m_pend && m_word == 32'h1000_0000 && m_phase == 32'h3000_0000) found = 1'b1;
            else step();
        end
        chk("reach_phase_3", found, 1);
        enable = 1'b0;
        repeat (20) step();
        chk("stopped_valid", dac_valid, 0);
        chk("stopped_data", dac_data, MID);

        // Restart, leave a config pending, then reset mid-run
        enable = 1'b1;
        repeat (20) step();
        send_cfg(32'h0200_0000, 2'd1, 8'h00);
        RST_n = 1'b0;
        #1;
        chk("midrun_rst_data", dac_data, MID);
        chk("midrun_rst_valid", dac_valid, 0);
        chk("midrun_rst_sync", sync_pulse, 0);
        chk("midrun_rst_ready", cfg_ready, 1);
        model_reset();
        @(negedge FPGA_CLK);
        @(negedge FPGA_CLK);
        RST_n = 1'b1;

        // Zero word in RUN: a pending config applies on the next cycle
        repeat (3) step();
        send_cfg(32'h0400_0000, 2'd1, 8'h00);
        chk("w0_ready_low", cfg_ready, 0);
        step();
        chk("w0_ready_back", cfg_ready, 1);
        repeat (20) step();

        // Random stimulus
        for (int i = 0; i < 500; i++) begin
            enable    = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            freq_word = ($urandom_range(0, 9) == 0) ? '0 : ($urandom >> $urandom_range(0, 10));
            wave_sel  = 2'($urandom_range(0, 3));
            duty      = DAC_W'($urandom);
            step();
        end
        cfg_valid = 1'b0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
